// File: rtl/game_pkg.sv
// Shared game constants, bomb FSM state type and sprite helpers.
// Also consumed by the plane, player and colour mapper blocks.
package game_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int GROUND_Y    = 440;
  localparam int BOMB_W      = 12;
  localparam int BOMB_H      = 12;
  localparam int DROP_Y_OFF  = 19;
  localparam int FALL_STEP   = 2;
  localparam int CHAR_W      = 20;
  localparam int CHAR_H      = 30;
  localparam int EXPL_FRAMES = 30;
  localparam int PHASE_LEN   = EXPL_FRAMES / 3;
  localparam int SPRITE_SZ   = BOMB_W * BOMB_H;
  localparam int CNT_W       = $clog2(EXPL_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    EXPLODE
  } bomb_state_t;

  // ROM base of the explosion frame shown for a given frame count
  function automatic logic [15:0] expl_base(
    input logic [CNT_W-1:0] cnt
  );
    if (cnt < CNT_W'(PHASE_LEN))
      return 16'(SPRITE_SZ);
    else if (cnt < CNT_W'(2 * PHASE_LEN))
      return 16'(2 * SPRITE_SZ);
    else
      return 16'(3 * SPRITE_SZ);
  endfunction

endpackage

// File: rtl/bomb_drop_if.sv
// Launch handshake between the enemy plane and the bomb.
// The plane drives the drop request, the bomb reports when it is re-armed.
interface bomb_drop_if;

  logic       launch;
  logic [9:0] start_x;
  logic [9:0] start_y;
  logic       explored;

  modport master (
    output launch,
    output start_x,
    output start_y,
    input  explored
  );

  modport slave (
    input  launch,
    input  start_x,
    input  start_y,
    output explored
  );

endinterface

// File: rtl/frame_edge_det.sv
// Turns the slow frame strobe into a one-Clk pulse in the Clk domain.
// Output lags the strobe rising edge by two Clk cycles.
module frame_edge_det (
  input  logic Clk,
  input  logic frame_clk,
  output logic fe
);

  logic frame_d;

  always_ff @(posedge Clk) begin
    frame_d <= frame_clk;
    fe      <= frame_clk & ~frame_d;
  end

endmodule

// File: rtl/bomb_drop.sv
// Falling bomb: latches a drop, falls per frame, detects impact,
// plays a three-phase explosion and drives the sprite draw path.
module bomb_drop
  import game_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  bomb_drop_if.slave  lnch,
  input  logic [9:0]  char_x,
  input  logic [9:0]  char_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic        hit,
  output logic        is_bomb,
  output logic [15:0] addr,
  output logic [9:0]  bomb_x,
  output logic [9:0]  bomb_y
);

  bomb_state_t      state, state_n;
  logic [9:0]       bx_n, by_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hit_n;
  logic             expl_q, expl_n;
  logic             fe;
  logic [10:0]      drop_y, fall_y;
  logic             overlap;

  frame_edge_det u_fe (
    .Clk       (Clk),
    .frame_clk (frame_clk),
    .fe        (fe)
  );

  assign lnch.explored = expl_q;

  assign drop_y = {1'b0, lnch.start_y} + 11'(DROP_Y_OFF);
  assign fall_y = {1'b0, bomb_y} + 11'(FALL_STEP);

  // 11-bit compares so edges near 1023 cannot wrap
  assign overlap =
    ({1'b0, bomb_x} + 11'(BOMB_W) > {1'b0, char_x}) &&
    ({1'b0, bomb_x} < {1'b0, char_x} + 11'(CHAR_W)) &&
    ({1'b0, bomb_y} + 11'(BOMB_H) > {1'b0, char_y}) &&
    ({1'b0, bomb_y} < {1'b0, char_y} + 11'(CHAR_H));

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      bomb_x <= '0;
      bomb_y <= '0;
      cnt    <= '0;
      hit    <= 1'b0;
      expl_q <= 1'b1;
    end else begin
      state  <= state_n;
      bomb_x <= bx_n;
      bomb_y <= by_n;
      cnt    <= cnt_n;
      hit    <= hit_n;
      expl_q <= expl_n;
    end
  end

  always_comb begin
    state_n = state;
    bx_n    = bomb_x;
    by_n    = bomb_y;
    cnt_n   = cnt;
    hit_n   = 1'b0;
    expl_n  = expl_q;
    unique case (state)
      IDLE: begin
        expl_n = 1'b1;
        if (lnch.launch) begin
          state_n = FALL;
          bx_n    = lnch.start_x;
          by_n    = (drop_y >= 11'(GROUND_Y)) ?
                    10'(GROUND_Y) : drop_y[9:0];
          expl_n  = 1'b0;
        end
      end
      FALL: begin
        if (fe) begin
          if (overlap) begin
            hit_n   = 1'b1;
            state_n = EXPLODE;
          end else if (fall_y >= 11'(GROUND_Y)) begin
            by_n    = 10'(GROUND_Y);
            state_n = EXPLODE;
          end else begin
            by_n = fall_y[9:0];
          end
        end
      end
      EXPLODE: begin
        if (fe) begin
          if (cnt == CNT_W'(EXPL_FRAMES - 1)) begin
            cnt_n   = '0;
            state_n = IDLE;
            expl_n  = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [10:0] dx, dy;
  logic [15:0] base;

  assign dx = {1'b0, DrawX} - {1'b0, bomb_x};
  assign dy = {1'b0, DrawY} - {1'b0, bomb_y};

  assign is_bomb = (state != IDLE) &&
                   !dx[10] && (dx[9:0] < 10'(BOMB_W)) &&
                   !dy[10] && (dy[9:0] < 10'(BOMB_H));

  assign base = (state == EXPLODE) ? expl_base(cnt) : 16'd0;

  assign addr = is_bomb ?
                16'(dy[9:0]) * 16'(BOMB_W) + 16'(dx[9:0]) + base :
                16'd0;

endmodule

// File: tb/tb_bomb_drop.sv
// Self-checking bench for bomb_drop: directed table, corner sequences
// and randomized traffic against a frame-level behavioural model.
module tb_bomb_drop;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [9:0]  char_x, char_y, DrawX, DrawY;
  logic        hit, is_bomb;
  logic [15:0] addr;
  logic [9:0]  bomb_x, bomb_y;

  bomb_drop_if lif ();

  bomb_drop dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .lnch      (lif),
    .char_x    (char_x),
    .char_y    (char_y),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .hit       (hit),
    .is_bomb   (is_bomb),
    .addr      (addr),
    .bomb_x    (bomb_x),
    .bomb_y    (bomb_y)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  // model: mode 0 = armed, 1 = falling, 2 = exploding
  int m_mode = 0, m_x = 0, m_y = 0, m_cnt = 0;
  bit m_hit = 0;
  bit f1 = 0, f2 = 0;

  int  hit_seen = 0;
  bit  track_relaunch = 0;
  bit  prev_expl = 1;
  int  rises = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit fe;
    fe = f1 & ~f2;
    f2 = f1;
    f1 = frame_clk;
    if (!Reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0; m_hit = 0;
      return;
    end
    m_hit = 0;
    if (m_mode == 0) begin
      if (lif.launch) begin
        m_mode = 1;
        m_x = lif.start_x;
        m_y = lif.start_y + 19;
        if (m_y > 440) m_y = 440;
      end
    end else if (m_mode == 1) begin
      if (fe) begin
        if (m_x + 12 > char_x && m_x < char_x + 20 &&
            m_y + 12 > char_y && m_y < char_y + 30) begin
          m_hit = 1; m_mode = 2;
        end else if (m_y + 2 >= 440) begin
          m_y = 440; m_mode = 2;
        end else begin
          m_y = m_y + 2;
        end
      end
    end else if (fe) begin
      if (m_cnt == 29) begin
        m_cnt = 0; m_mode = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_all();
    int dx, dy, e_in, e_addr;
    dx = int'(DrawX) - m_x;
    dy = int'(DrawY) - m_y;
    e_in = (m_mode != 0 && dx >= 0 && dx < 12 && dy >= 0 && dy < 12);
    e_addr = 0;
    if (e_in) begin
      e_addr = dy * 12 + dx;
      if (m_mode == 2) e_addr += 144 * (m_cnt / 10 + 1);
    end
    chk("explored", lif.explored, m_mode == 0);
    chk("hit", hit, m_hit);
    chk("bomb_x", bomb_x, m_x);
    chk("bomb_y", bomb_y, m_y);
    chk("is_bomb", is_bomb, e_in);
    chk("addr", addr, e_addr);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    check_all();
    if (hit === 1'b1) hit_seen++;
    if (track_relaunch) begin
      if (prev_expl) chk("relaunch", lif.explored, 0);
      if (!prev_expl && lif.explored === 1'b1) rises++;
    end
    prev_expl = lif.explored;
  endtask

  task automatic frame_edge();
    frame_clk = 1'b1;
    repeat (4) tick();
    frame_clk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    lif.launch = 1'b0;
    frame_clk = 1'b0;
    repeat (2) tick();
    Reset = 1'b1;
    tick();
  endtask

  task automatic drop(input int sx, input int sy);
    lif.start_x = 10'(sx);
    lif.start_y = 10'(sy);
    lif.launch = 1'b1;
    tick();
    lif.launch = 1'b0;
  endtask

  typedef struct {
    bit rst;
    bit launch;
    int sx, sy, px, py;
    int e_expl, e_by, e_isb, e_addr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0;
    Reset = 1'b0;
    frame_clk = 1'b0;
    lif.launch = 1'b0;
    lif.start_x = '0;
    lif.start_y = '0;
    char_x = '0; char_y = '0;
    DrawX = '0; DrawY = '0;

    tbl[0] = '{0, 1,   0,   0,   0,   0, 1,   0, 0,  0};
    tbl[1] = '{0, 1,   0,   0,   0,   0, 1,   0, 0,  0};
    tbl[2] = '{0, 1,   0,   0,   0,   0, 1,   0, 0,  0};
    tbl[3] = '{1, 0,   0,   0,   0,   0, 1,   0, 0,  0};
    tbl[4] = '{1, 1, 300, 100, 303, 121, 0, 119, 1, 27};
    tbl[5] = '{1, 0, 300, 100, 312, 119, 0, 119, 0,  0};
    tbl[6] = '{1, 1,  10,  10, 300, 119, 0, 119, 1,  0};
    tbl[7] = '{0, 1,  10,  10, 300, 119, 1,   0, 0,  0};

    for (int i = 0; i < 8; i++) begin
      Reset = tbl[i].rst;
      lif.launch = tbl[i].launch;
      lif.start_x = 10'(tbl[i].sx);
      lif.start_y = 10'(tbl[i].sy);
      DrawX = 10'(tbl[i].px);
      DrawY = 10'(tbl[i].py);
      tick();
      chk("tbl_explored", lif.explored, tbl[i].e_expl);
      chk("tbl_bomb_y", bomb_y, tbl[i].e_by);
      chk("tbl_is_bomb", is_bomb, tbl[i].e_isb);
      chk("tbl_addr", addr, tbl[i].e_addr);
    end

    // fall all the way to the ground, then explode and re-arm
    do_reset();
    char_x = 10'd0; char_y = 10'd0;
    h0 = hit_seen;
    drop(300, 100);
    chk("launch_y", bomb_y, 119);
    repeat (160) frame_edge();
    chk("y_439", bomb_y, 439);
    frame_edge();
    chk("y_ground", bomb_y, 440);
    repeat (29) frame_edge();
    chk("expl_busy", lif.explored, 0);
    frame_edge();
    chk("rearmed", lif.explored, 1);
    chk("ground_no_hit", hit_seen - h0, 0);

    // strike the player, then walk the explosion phases
    do_reset();
    char_x = 10'd295; char_y = 10'd150;
    h0 = hit_seen;
    drop(300, 100);
    for (int i = 0; i < 60 && hit_seen == h0; i++) frame_edge();
    chk("hit_once", hit_seen - h0, 1);
    chk("hit_y", bomb_y, 139);
    DrawX = 10'd303; DrawY = 10'd141;
    repeat (5) frame_edge();
    chk("addr_ph0", addr, 171);
    chk("frozen_y", bomb_y, 139);
    repeat (10) frame_edge();
    chk("addr_ph1", addr, 315);
    repeat (10) frame_edge();
    chk("addr_ph2", addr, 459);
    repeat (5) frame_edge();
    chk("hit_rearm", lif.explored, 1);
    chk("hit_total", hit_seen - h0, 1);

    // launch held high: re-drop exactly one Clk after re-arm
    do_reset();
    char_x = 10'd600; char_y = 10'd0;
    lif.start_x = 10'd100; lif.start_y = 10'd400;
    lif.launch = 1'b1;
    track_relaunch = 1;
    prev_expl = 1;
    rises = 0;
    repeat (45) frame_edge();
    lif.start_x = 10'd500;
    repeat (45) frame_edge();
    track_relaunch = 0;
    lif.launch = 1'b0;
    chk("relaunch_count", rises >= 2, 1);

    // reset mid-fall
    do_reset();
    char_x = 10'd600; char_y = 10'd0;
    h0 = hit_seen;
    drop(300, 101);
    for (int i = 0; i < 100 && m_y != 250; i++) frame_edge();
    chk("mid_y", bomb_y, 250);
    Reset = 1'b0;
    tick();
    chk("abort_expl", lif.explored, 1);
    chk("abort_y", bomb_y, 0);
    chk("abort_hit", hit_seen - h0, 0);
    Reset = 1'b1;
    tick();

    // drop below ground clamps and explodes on first edge
    drop(50, 425);
    chk("clamp_y", bomb_y, 440);
    frame_edge();
    chk("clamp_busy", lif.explored, 0);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 299) != 0);
      lif.launch = ($urandom_range(0, 9) == 0);
      lif.start_x = 10'($urandom_range(0, 639));
      lif.start_y = 10'($urandom_range(0, 460));
      if ($urandom_range(0, 49) == 0) begin
        char_x = 10'($urandom_range(0, 619));
        char_y = 10'($urandom_range(0, 449));
      end
      if ($urandom_range(0, 1) == 1) begin
        DrawX = 10'((m_x + $urandom_range(0, 16) - 2) & 1023);
        DrawY = 10'((m_y + $urandom_range(0, 16) - 2) & 1023);
      end else begin
        DrawX = 10'($urandom_range(0, 1023));
        DrawY = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 5) == 0) frame_clk = ~frame_clk;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bomb_drop.md
Name: bomb_drop

Overview:
- Receiving end of the enemy plane's launch interface.
- On a `launch` pulse it latches the plane's drop coordinates. It then animates a falling bomb at frame rate and detects impact with the player character or the ground.
- After impact it plays a three-phase explosion sprite and then re-arms.
- It drives `explored` back to the plane, high only when a new bomb may be launched. It also drives pixel-level sprite outputs to the colour mapper and a `hit` pulse to the player logic.

Parameters:
- BOMB_W, 12, bomb/explosion sprite width in pixels
- BOMB_H, 12, sprite height in pixels
- DROP_Y_OFF, 19, vertical offset added to start_y (plane half-height)
- FALL_STEP, 2, pixels descended per frame
- GROUND_Y, 440, y of ground line; bomb top clamps here
- CHAR_W, 20, player hitbox width
- CHAR_H, 30, player hitbox height
- EXPL_FRAMES, 30, explosion duration in frames (3 phases of EXPL_FRAMES/3)

Ports:
- Clk  input  1  50 MHz system clock
- Reset  input  1  synchronous, active-low reset (0 = reset)
- frame_clk  input  1  ~60 Hz frame strobe
- launch  input  1  drop request from plane, level-sampled every Clk
- start_x  input  10  plane x at launch
- start_y  input  10  plane y at launch
- char_x  input  10  player hitbox left x
- char_y  input  10  player hitbox top y
- DrawX  input  10  current pixel x
- DrawY  input  10  current pixel y
- explored  output  1  1 = idle/ready for next launch
- hit  output  1  one-Clk pulse when bomb strikes player
- is_bomb  output  1  current pixel lies inside active bomb sprite
- addr  output  16  sprite ROM address for current pixel
- bomb_x  output  10  current bomb left x
- bomb_y  output  10  current bomb top y

Behaviour:
- Frame edge: `frame_clk` is registered into `frame_d`. `fe = frame_clk & ~frame_d` is registered again, giving a 1-Clk pulse two Clk after the rising edge.
- Reset (Reset==0 at posedge Clk), overriding everything including a coincident launch:
  - state=IDLE, bomb_x=0, bomb_y=0, expl_cnt=0, hit=0, explored=1.
  - is_bomb=0, addr=0.
- Mid-flight or mid-explosion reset aborts immediately to IDLE.
- States: IDLE, FALL, EXPLODE. All outputs except is_bomb and addr are registered.
- IDLE:
  - explored=1.
  - launch==1 at a posedge: next cycle state=FALL, bomb_x=start_x, bomb_y=start_y+DROP_Y_OFF (clamped to GROUND_Y), explored=0.
  - Launch latency is 1 Clk.
- FALL:
  - launch is ignored; explored=0. Position updates only on `fe`.
  - Player hit test uses the current position, 11-bit unsigned, no wrap. Hit when all of:
    - bomb_x+BOMB_W > char_x
    - bomb_x < char_x+CHAR_W
    - bomb_y+BOMB_H > char_y
    - bomb_y < char_y+CHAR_H
  - On hit: hit=1 for exactly one Clk; state=EXPLODE; position frozen.
  - Else if bomb_y+FALL_STEP >= GROUND_Y: bomb_y=GROUND_Y; state=EXPLODE; hit stays 0.
  - Else: bomb_y += FALL_STEP.
  - If hit and ground conditions hold simultaneously, hit wins.
- EXPLODE:
  - expl_cnt increments on each `fe`.
  - On `fe` with expl_cnt==EXPL_FRAMES-1: expl_cnt=0, state=IDLE, explored=1.
  - Phase = 0/1/2 for expl_cnt in [0,10), [10,20), [20,30) with default parameters.
- Draw path (combinational):
  - dx = DrawX-bomb_x, dy = DrawY-bomb_y, both 11-bit signed.
  - is_bomb = (state!=IDLE) && 0<=dx<BOMB_W && 0<=dy<BOMB_H.
  - addr = dy*BOMB_W + dx + base when is_bomb, else 0.
  - base = 0 in FALL; BOMB_W*BOMB_H*(phase+1) in EXPLODE, i.e. 144/288/432 with defaults.
- start_y+DROP_Y_OFF >= GROUND_Y: the bomb sits at GROUND_Y and goes to EXPLODE on the first `fe`.
- bomb_x is never modified after latch. Sprites near x=639 simply clip via the DrawX range.

Decomposition:
- Shared package `game_pkg`:
  - `bomb_state_t` enum (IDLE, FALL, EXPLODE).
  - Constants GROUND_Y, SCREEN_W=640, SCREEN_H=480.
  - Sprite size constants, also used by the colour mapper.
- One natural sub-module `frame_edge_det` (Clk, frame_clk -> fe). It is reusable by the plane and player modules.
- Hit test and draw/address logic stay inline.

Test Plan:
- Reset low 3 cycles while launch=1: explored=1, is_bomb=0, bomb_y=0. Release reset with launch=0: state stays IDLE.
- Launch with start=(300,100), player at (0,0): one Clk later explored=0, bomb=(300,119).
  - After 160 frame edges: bomb_y=439.
  - Next edge: bomb_y=440, EXPLODE, hit never asserted.
  - 30 edges later: explored=1.
- Launch with start=(300,100), player at (295,150): hit pulses exactly one Clk on the edge where bomb_y reaches 139. bomb_y freezes at 139.
- During EXPLODE pixel (bomb_x+3, bomb_y+2) returns addr:
  - expl_cnt=5: 144+27=171.
  - expl_cnt=15: 315.
  - expl_cnt=25: 459.
  - In FALL it returns 27. Pixel (bomb_x+12, bomb_y) gives is_bomb=0, addr=0.
- Launch held high continuously: bomb cycles FALL→EXPLODE→IDLE, and a new drop starts exactly 1 Clk after explored rises. Launch pulses during FALL/EXPLODE are ignored.
- Reset asserted mid-FALL at bomb_y=250: next cycle IDLE, explored=1, bomb_y=0, no hit pulse.
